// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART MMIO controller: register offsets and STATUS layout.
package uart_mmio_pkg;

    localparam logic [7:0] OffStatus   = 8'h00;
    localparam logic [7:0] OffRxData   = 8'h04;
    localparam logic [7:0] OffTxData   = 8'h08;
    localparam logic [7:0] OffCycle    = 8'h10;
    localparam logic [7:0] OffCycleClr = 8'h18;

    localparam int unsigned StTxReady    = 0;
    localparam int unsigned StRxValid    = 1;
    localparam int unsigned StTxDrop     = 2;
    localparam int unsigned StRxCountLsb = 8;
    localparam int unsigned StRxCountW   = 8;

    function automatic logic [31:0] pack_status(logic tx_ready, logic rx_valid, logic tx_drop,
                                                logic [StRxCountW-1:0] rx_count);
        logic [31:0] word;
        word = '0;
        word[StTxReady] = tx_ready;
        word[StRxValid] = rx_valid;
        word[StTxDrop]  = tx_drop;
        word[StRxCountLsb +: StRxCountW] = rx_count;
        return word;
    endfunction

endpackage

// File: rtl/uart_mmio_ctrl_sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two >= 2.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned Aw = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [Aw-1:0]    wptr_q, wptr_d;
    logic [Aw-1:0]    rptr_q, rptr_d;
    logic [Aw:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (Aw+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // Requests against a full/empty FIFO are ignored here as a safety net.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// MMIO front end for the on-chip UART: TX holding register, RX path and cycle counter.
// Define UART_RX_FIFO_EN to buffer received bytes in a RX_FIFO_DEPTH-entry FIFO.
module uart_mmio_ctrl
    import uart_mmio_pkg::*;
#(
    parameter logic [3:0]  IO_BASE_NIBBLE = 4'h8,
    parameter int unsigned RX_FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    input  logic        io_we,
    input  logic        io_re,
    output logic [31:0] io_rdata,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    localparam int unsigned CntW = $clog2(RX_FIFO_DEPTH) + 1;

    logic        sel;
    logic [7:0]  off;
    logic        rd_status, rd_rx, wr_tx, wr_clr;

    logic        hold_full_q, hold_full_d;
    logic [7:0]  hold_data_q, hold_data_d;
    logic        tx_drop_q, tx_drop_d;
    logic        tx_xfer;

    logic [31:0] cycle_q, cycle_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] rd_val;

    logic            rx_avail;
    logic [7:0]      rx_byte;
    logic [CntW-1:0] rx_cnt_raw;
    logic [7:0]      rx_count;

    logic unused_bits;
    assign unused_bits = ^{io_addr[27:8], io_wdata[31:8]};

    assign sel       = (io_addr[31:28] == IO_BASE_NIBBLE);
    assign off       = io_addr[7:0];
    assign rd_status = io_re && sel && (off == OffStatus);
    assign rd_rx     = io_re && sel && (off == OffRxData);
    assign wr_tx     = io_we && sel && (off == OffTxData);
    assign wr_clr    = io_we && sel && (off == OffCycleClr);

`ifdef UART_RX_FIFO_EN
    logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [7:0] fifo_rdata;

    assign uart_rx_ready = !fifo_full;
    assign fifo_push     = uart_rx_valid && !fifo_full;
    assign fifo_pop      = rd_rx && !fifo_empty;
    assign rx_avail      = !fifo_empty;
    assign rx_byte       = fifo_rdata;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (fifo_push),
        .wdata_i (uart_rx_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (rx_cnt_raw)
    );
`else
    // Unbuffered: the UART byte is consumed directly by the RX_DATA read.
    assign uart_rx_ready = rd_rx && uart_rx_valid;
    assign rx_avail      = uart_rx_valid;
    assign rx_byte       = uart_rx_data;
    assign rx_cnt_raw    = CntW'(uart_rx_valid);
`endif

    assign rx_count = 8'(rx_cnt_raw);

    assign tx_xfer       = hold_full_q && uart_tx_ready;
    assign uart_tx_valid = hold_full_q;
    assign uart_tx_data  = hold_data_q;
    assign io_rdata      = rdata_q;

    always_comb begin
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        tx_drop_d   = tx_drop_q;
        if (tx_xfer) hold_full_d = 1'b0;
        // A drop raised in the same cycle as a STATUS read must survive the clear.
        if (rd_status) tx_drop_d = 1'b0;
        if (wr_tx) begin
            if (!hold_full_q || tx_xfer) begin
                hold_full_d = 1'b1;
                hold_data_d = io_wdata[7:0];
            end else begin
                tx_drop_d = 1'b1;
            end
        end
    end

    assign cycle_d = wr_clr ? 32'd0 : cycle_q + 32'd1;

    always_comb begin
        rd_val = '0;
        if (sel) begin
            case (off)
                OffStatus: rd_val = pack_status(!hold_full_q, rx_avail, tx_drop_q, rx_count);
                OffRxData: rd_val = {24'd0, rx_avail ? rx_byte : 8'd0};
                // Reports the count including the read cycle itself.
                OffCycle:  rd_val = cycle_q + 32'd1;
                default:   rd_val = '0;
            endcase
        end
        rdata_d = io_re ? rd_val : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full_q <= 1'b0;
            hold_data_q <= 8'd0;
            tx_drop_q   <= 1'b0;
            cycle_q     <= 32'd0;
            rdata_q     <= 32'd0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            tx_drop_q   <= tx_drop_d;
            cycle_q     <= cycle_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule

// File: doc/uart_mmio_ctrl.md
# uart_mmio_ctrl

Memory-mapped controller that sits between the Riscv151 load/store path and the on-chip `uart`, decoding the I/O region at 0x8000_0000. It sequences the UART ready/valid handshakes on behalf of software: a transmit holding register, a buffered receive path and a free-running cycle counter, with synchronous one-cycle read latency matching the CPU's memory timing. This replaces ad-hoc MMIO glue inside the CPU top.

## Interface
- `IO_BASE_NIBBLE`, 4'h8: value of `io_addr[31:28]` that selects this block
- `RX_FIFO_DEPTH`, 8: receive FIFO entries, power of two, ≥2 (used only with `UART_RX_FIFO_EN`)

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `io_addr`  in  32  byte address from CPU load/store stage
- `io_wdata`  in  32  store data
- `io_we`  in  1  store strobe, one cycle per store
- `io_re`  in  1  load strobe, one cycle per load
- `io_rdata`  out  32  load data, valid the cycle after `io_re`
- `uart_tx_data`  out  8  byte to UART transmitter
- `uart_tx_valid`  out  1  transmit byte available
- `uart_tx_ready`  in  1  UART transmitter accepts
- `uart_rx_data`  in  8  byte from UART receiver
- `uart_rx_valid`  in  1  UART receiver has byte
- `uart_rx_ready`  out  1  controller accepts received byte

## Operation
- Selected when `io_addr[31:28] == IO_BASE_NIBBLE`; offset = `io_addr[7:0]`. Unselected or unmapped: reads return 0, writes ignored, no side effects.
- Register map:
  - 0x00 STATUS RO: [0] tx_ready = holding empty; [1] rx_valid = receive data available; [2] tx_drop sticky; [15:8] rx count (0..RX_FIFO_DEPTH); rest 0. Reading clears tx_drop (read returns pre-clear value).
  - 0x04 RX_DATA RO: [7:0] oldest received byte, zero-extended; read pops it. Read when empty returns 0, no pop.
  - 0x08 TX_DATA WO: `io_wdata[7:0]` loaded into holding register.
  - 0x10 CYCLE RO: 32-bit cycle counter.
  - 0x18 CYCLE_CLR WO: any write clears counter.
- TX: `uart_tx_valid` = holding full; `uart_tx_data` = holding register. Transfer on `uart_tx_valid && uart_tx_ready` empties it. Write to 0x08 accepted if holding empty or a transfer completes the same cycle (new byte loaded, stays full); otherwise byte dropped and tx_drop set.
- RX: `uart_rx_ready` = FIFO not full (registered-state derived, no combinational path from `io_re`). Push on `uart_rx_valid && uart_rx_ready`. Push and pop same cycle: count unchanged, both take effect. Full FIFO back-pressures the UART; no bytes lost.
- CYCLE: +1 every cycle, wraps 0xFFFF_FFFF→0. Clear write forces 0 that cycle; counts from 1 the next.

## Timing
- Reset: `io_rdata`=0, `uart_tx_valid`=0, `uart_tx_data`=0, `uart_rx_ready`=1 (FIFO empty), tx_drop=0, CYCLE=0, FIFO pointers/count=0. Reset mid-transfer discards holding and FIFO contents.
- Read latency 1: `io_rdata` registered from state at the `io_re` edge; pop/clear side effects committed at the same edge. Back-to-back reads of 0x04 return consecutive bytes.
- Write effects visible to a read issued the following cycle.
- `io_we` and `io_re` both high same cycle: both performed, read sees pre-write state.
- `io_rdata` holds its value when `io_re` low.

## Configuration
- `UART_RX_FIFO_EN` defined: RX path is a `RX_FIFO_DEPTH`-entry FIFO as above.
- Not defined: no storage; `uart_rx_ready` pulses for the cycle of a 0x04 read while `uart_rx_valid`=1, RX_DATA captures `uart_rx_data` directly, rx count reads 0 or 1 (= `uart_rx_valid`). Register map and latency unchanged.

## Structure
- Package `uart_mmio_pkg`: register offsets (STATUS, RX_DATA, TX_DATA, CYCLE, CYCLE_CLR) and STATUS bit positions/field widths.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/count), instantiated only under `UART_RX_FIFO_EN`.

## Test plan
- Reset, read 0x00 → 0x0000_0001; read 0x10 after 10 idle cycles → 0x0000_000A ±1 per read edge; CYCLE_CLR write then read next cycle → 0x0000_0001.
- Write 0x7A to 0x08 with `uart_tx_ready`=0 → `uart_tx_valid`=1, data 0x7A, STATUS[0]=0; second write 0x55 → dropped, STATUS reads 0x4 then 0x0; raise ready → one transfer of 0x7A only.
- Drive bytes 0x11,0x22,0x33 into RX → STATUS[15:8]=3, [1]=1; three back-to-back 0x04 reads → 0x11,0x22,0x33; fourth → 0, count 0.
- Push 9 bytes with depth 8 → `uart_rx_ready` drops after 8th, 9th held by UART; one pop → 9th accepted next cycle, count stays 8.
- Holding full, `uart_tx_ready`=1 and write 0x42 same cycle → old byte transferred, 0x42 loaded, tx_drop stays 0.
- Echo loop with real `uart` instances: off-chip sends 0x7A, software-equivalent bench polls STATUS, reads 0x04, writes 0x08 → off-chip receives 0x7A.
